// File: rtl/mem_store_ctrl_if.sv
// mem_store_ctrl_if: bundles the pipeline store handshake, the load-hazard
// probe and the memory write bus of the store-side controller.
//   slave  : the controller's view (takes stores, drives the memory bus)
//   master : the environment's view (pipeline + memory model)
// Store side : st_valid/st_ready, st_addr, st_data, st_size, st_except, exc_addr
// Load probe : ld_valid, ld_addr, ld_hazard
// Memory bus : mem_req, mem_addr, mem_wdata, mem_be, mem_ack
// Status     : sb_empty
interface mem_store_ctrl_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_except;
    logic [31:0] exc_addr;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        sb_empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, mem_ack,
        output st_ready, st_except, exc_addr, ld_hazard,
               mem_req, mem_addr, mem_wdata, mem_be, sb_empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, mem_ack,
        input  st_ready, st_except, exc_addr, ld_hazard,
               mem_req, mem_addr, mem_wdata, mem_be, sb_empty
    );
endinterface

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: store-side memory controller between MEM and the data
// memory write bus. Aligns accepted stores into byte lanes + byte enables,
// queues them in an in-order buffer of DEPTH entries and issues them one at
// a time on a req/ack bus. Loads whose word matches a buffered store raise
// ld_hazard.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_store_ctrl_if.slave (store handshake, load probe, memory bus)
module mem_store_ctrl #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            rst,
    mem_store_ctrl_if.slave bus
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    state_t           state;
    logic             mem_req;
    logic             st_except;
    logic [31:0]      exc_addr;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_nxt;

    logic [29:0] q_addr [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [3:0]  q_be   [DEPTH];

    logic        accept, misalign, reserved, enq, pop;
    logic [31:0] al_data;
    logic [3:0]  al_be;
    logic [DEPTH-1:0] hit;

    // Lane alignment: data is right-justified on input and shifted into the
    // lanes selected by the low address bits; bits shifted past 31 drop.
    always_comb begin
        al_be    = '0;
        al_data  = '0;
        misalign = 1'b0;
        reserved = 1'b0;
        case (bus.st_size)
            2'b00: begin
                al_be   = 4'b0001 << bus.st_addr[1:0];
                al_data = bus.st_data << {bus.st_addr[1:0], 3'b000};
            end
            2'b01: begin
                misalign = bus.st_addr[0];
                al_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                al_data  = bus.st_data << {bus.st_addr[1], 4'b0000};
            end
            2'b11: begin
                misalign = |bus.st_addr[1:0];
                al_be    = 4'b1111;
                al_data  = bus.st_data;
            end
            default: reserved = 1'b1;
        endcase
    end

    assign bus.st_ready = (count != CNT_FULL);
    assign accept       = bus.st_valid & bus.st_ready;
    // Faulting and reserved-size stores are consumed but never enqueued.
    assign enq          = accept & ~misalign & ~reserved;
    assign pop          = mem_req & bus.mem_ack;
    assign count_nxt    = count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            st_except <= 1'b0;
            exc_addr  <= '0;
        end else begin
            count     <= count_nxt;
            st_except <= accept & misalign;
            if (accept & misalign) exc_addr <= bus.st_addr;
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case (state)
                IDLE: if (count != '0 || enq) begin
                    state   <= REQ;
                    mem_req <= 1'b1;
                end
                REQ: if (pop && count_nxt == '0) begin
                    // stays in REQ when a same-edge enqueue refills it
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Storage array carries no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= bus.st_addr[31:2];
            q_data[wr_ptr] <= al_data;
            q_be[wr_ptr]   <= al_be;
        end
    end

    // An entry is live when its distance from the head is below count;
    // this includes the head entry that is currently on the bus.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [PTR_W-1:0] off;
        assign off    = PTR_W'(i) - rd_ptr;
        assign hit[i] = ((PTR_W+1)'(off) < count) && (q_addr[i] == bus.ld_addr[31:2]);
    end

    assign bus.ld_hazard = bus.ld_valid & (|hit);
    assign bus.mem_req   = mem_req;
    assign bus.mem_addr  = mem_req ? q_addr[rd_ptr] : '0;
    assign bus.mem_wdata = mem_req ? q_data[rd_ptr] : '0;
    assign bus.mem_be    = mem_req ? q_be[rd_ptr]   : '0;
    assign bus.st_except = st_except;
    assign bus.exc_addr  = exc_addr;
    assign bus.sb_empty  = (count == '0) && (state == IDLE);

    // Byte offset of a load does not matter for word-granular hazard checks.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ld_addr[1:0]};
endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb_mem_store_ctrl: directed vectors with hand-computed expectations for
// mem_store_ctrl (DEPTH=2). Inputs change 1ns after the rising edge and
// outputs are checked 2ns after it, well clear of the next edge.
module tb_mem_store_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_store_ctrl_if bus ();

    mem_store_ctrl #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_size  = sz;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_size  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bus.ld_valid = 1'b1;
        #1;
        check("rst_ready",  32'(bus.st_ready), 32'd1);
        check("rst_empty",  32'(bus.sb_empty), 32'd1);
        check("rst_hazard", 32'(bus.ld_hazard), 32'd0);
        check("rst_req",    32'(bus.mem_req), 32'd0);
        check("rst_exc",    32'(bus.st_except), 32'd0);
        check("rst_excadr", bus.exc_addr, 32'd0);
        bus.ld_valid = 1'b0;

        // word store, ack tied high
        bus.mem_ack = 1'b1;
        put(32'h1000, 32'hDEADBEEF, 2'b11);
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("w_req",   32'(bus.mem_req), 32'd1);
        check("w_addr",  32'(bus.mem_addr), 32'h400);
        check("w_be",    32'(bus.mem_be), 32'hF);
        check("w_data",  bus.mem_wdata, 32'hDEADBEEF);
        tick();
        #1;
        check("w_idle",  32'(bus.mem_req), 32'd0);
        check("w_empty", 32'(bus.sb_empty), 32'd1);
        check("w_zaddr", 32'(bus.mem_addr), 32'd0);

        // byte then half, back-to-back
        put(32'h2003, 32'h000000AB, 2'b00);
        tick();
        put(32'h2002, 32'h00001234, 2'b01);
        #1;
        check("b_req",  32'(bus.mem_req), 32'd1);
        check("b_addr", 32'(bus.mem_addr), 32'h800);
        check("b_be",   32'(bus.mem_be), 32'h8);
        check("b_data", bus.mem_wdata, 32'hAB000000);
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("h_req",  32'(bus.mem_req), 32'd1);
        check("h_addr", 32'(bus.mem_addr), 32'h800);
        check("h_be",   32'(bus.mem_be), 32'hC);
        check("h_data", bus.mem_wdata, 32'h12340000);
        tick();
        #1;
        check("bh_idle", 32'(bus.mem_req), 32'd0);
        check("bh_empty", 32'(bus.sb_empty), 32'd1);

        // misaligned half, misaligned word, reserved size
        bus.mem_ack = 1'b0;
        put(32'h11, 32'h5555, 2'b01);
        tick();
        put(32'h22, 32'h6666, 2'b11);
        #1;
        check("mh_exc",  32'(bus.st_except), 32'd1);
        check("mh_addr", bus.exc_addr, 32'h11);
        check("mh_req",  32'(bus.mem_req), 32'd0);
        tick();
        put(32'h30, 32'h7777, 2'b10);
        #1;
        check("mw_exc",  32'(bus.st_except), 32'd1);
        check("mw_addr", bus.exc_addr, 32'h22);
        check("mw_req",  32'(bus.mem_req), 32'd0);
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("rs_exc",   32'(bus.st_except), 32'd0);
        check("rs_addr",  bus.exc_addr, 32'h22);
        check("rs_req",   32'(bus.mem_req), 32'd0);
        check("rs_empty", 32'(bus.sb_empty), 32'd1);
        tick();
        #1;
        check("rs_req2",  32'(bus.mem_req), 32'd0);

        // backpressure: ack held low, three stores offered
        put(32'h100, 32'h1, 2'b11);
        tick();
        put(32'h104, 32'h2, 2'b11);
        #1;
        check("bp_rdy1", 32'(bus.st_ready), 32'd1);
        check("bp_addr1", 32'(bus.mem_addr), 32'h40);
        tick();
        put(32'h108, 32'h3, 2'b11);
        #1;
        check("bp_full", 32'(bus.st_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("bp_hold_rdy",  32'(bus.st_ready), 32'd0);
            check("bp_hold_addr", 32'(bus.mem_addr), 32'h40);
            check("bp_hold_data", bus.mem_wdata, 32'h1);
        end
        bus.mem_ack = 1'b1;
        #1;
        check("bp_ack_rdy", 32'(bus.st_ready), 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check("bp_pop_rdy",  32'(bus.st_ready), 32'd1);
        check("bp_pop_addr", 32'(bus.mem_addr), 32'h41);
        check("bp_pop_data", bus.mem_wdata, 32'h2);
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("bp_c_full", 32'(bus.st_ready), 32'd0);
        check("bp_c_addr", 32'(bus.mem_addr), 32'h41);
        bus.mem_ack = 1'b1;
        tick();
        #1;
        check("bp_c_head", 32'(bus.mem_addr), 32'h42);
        check("bp_c_data", bus.mem_wdata, 32'h3);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check("bp_empty", 32'(bus.sb_empty), 32'd1);

        // load hazard against a pending store
        put(32'h3004, 32'h55, 2'b11);
        tick();
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h3006;
        #1;
        check("hz_hit", 32'(bus.ld_hazard), 32'd1);
        bus.ld_addr = 32'h3008;
        #1;
        check("hz_miss", 32'(bus.ld_hazard), 32'd0);
        bus.ld_addr  = 32'h3006;
        bus.ld_valid = 1'b0;
        #1;
        check("hz_noval", 32'(bus.ld_hazard), 32'd0);
        bus.ld_valid = 1'b1;
        bus.mem_ack  = 1'b1;
        #1;
        check("hz_ackcyc", 32'(bus.ld_hazard), 32'd1);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check("hz_clear", 32'(bus.ld_hazard), 32'd0);
        check("hz_empty", 32'(bus.sb_empty), 32'd1);
        bus.ld_valid = 1'b0;

        // reset mid-transaction with a full buffer
        put(32'h500, 32'hA, 2'b11);
        tick();
        put(32'h504, 32'hB, 2'b11);
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("mr_req",  32'(bus.mem_req), 32'd1);
        check("mr_full", 32'(bus.st_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mr_req0",  32'(bus.mem_req), 32'd0);
        check("mr_empty", 32'(bus.sb_empty), 32'd1);
        check("mr_ready", 32'(bus.st_ready), 32'd1);
        check("mr_exc",   32'(bus.st_except), 32'd0);
        tick();
        #1;
        check("mr_stay",  32'(bus.mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
